// File: rtl/pipeline_run_controller_pkg.sv
// rtl/pipeline_run_controller_pkg.sv - command codes, state encoding and helpers for the run controller
package pipeline_run_controller_pkg;

   localparam logic [2:0] CMD_NOP   = 3'd0;
   localparam logic [2:0] CMD_LOAD  = 3'd1;
   localparam logic [2:0] CMD_RUN   = 3'd2;
   localparam logic [2:0] CMD_STEP  = 3'd3;
   localparam logic [2:0] CMD_STOP  = 3'd4;
   localparam logic [2:0] CMD_FLUSH = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_RUN   = 3'd3,
      ST_STEP  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

   // Address width for a memory of the given depth, never less than one bit.
   function automatic int clogb2(input int depth);
      int width;
      width = 0;
      for (int v = depth - 1; v > 0; v = v >> 1) begin
         width++;
      end
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// rtl/pipeline_run_controller_sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
   parameter int NB_CNT = 32
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   output logic [NB_CNT-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_run_controller.sv
// rtl/pipeline_run_controller.sv - debug-driven load/run/step sequencer for the MIPS pipeline
module pipeline_run_controller
   import pipeline_run_controller_pkg::*;
#(
   parameter int                  NB_INSTR           = 32,
   parameter int                  N_ADDR             = 2048,
   parameter int                  LOG2_N_INSMEM_ADDR = clogb2(N_ADDR),
   parameter int                  NB_CNT             = 32,
   parameter int                  FLUSH_CYCLES       = 2,
   parameter logic [NB_INSTR-1:0] HALT_INSTR         = NB_INSTR'(HALT_INSTR_DEFAULT)
)(
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_cmd_valid,
   input  logic [2:0]                    i_cmd,
   output logic                          o_cmd_ready,
   input  logic                          i_load_valid,
   input  logic [NB_INSTR-1:0]           i_load_data,
   output logic                          o_load_ready,
   output logic                          o_imem_wr_en,
   output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_wr_addr,
   output logic [NB_INSTR-1:0]           o_imem_wr_data,
   input  logic                          i_halt_retired,
   output logic                          o_pipe_valid,
   output logic                          o_pipe_reset,
   output logic [NB_CNT-1:0]             o_cycle_count,
   output logic                          o_done,
   output logic [2:0]                    o_state
);

   localparam int NB_FLUSH = clogb2(FLUSH_CYCLES + 1);
   localparam logic [NB_FLUSH-1:0] FLUSH_LAST = NB_FLUSH'(FLUSH_CYCLES - 1);
   localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);

   state_t                          state;
   state_t                          state_next;
   logic [LOG2_N_INSMEM_ADDR-1:0]   load_addr;
   logic [NB_FLUSH-1:0]             flush_cnt;
   logic                            addr_clear;

   always_comb begin
      state_next     = state;
      addr_clear     = 1'b0;
      o_cmd_ready    = 1'b0;
      o_load_ready   = 1'b0;
      o_imem_wr_en   = 1'b0;
      o_imem_wr_addr = '0;
      o_imem_wr_data = '0;
      o_pipe_valid   = 1'b0;
      o_pipe_reset   = 1'b0;
      o_done         = 1'b0;
      case (state)
         ST_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               case (i_cmd)
                  CMD_LOAD:  begin state_next = ST_LOAD; addr_clear = 1'b1; end
                  CMD_RUN:   state_next = ST_RUN;
                  CMD_STEP:  state_next = ST_STEP;
                  CMD_FLUSH: state_next = ST_FLUSH;
                  default:   ;
               endcase
            end
         end
         ST_LOAD: begin
            o_load_ready   = 1'b1;
            o_imem_wr_en   = i_load_valid;
            o_imem_wr_addr = load_addr;
            o_imem_wr_data = i_load_data;
            // The last memory word ends the load as a halt does; the address never wraps.
            if (i_load_valid && ((i_load_data == HALT_INSTR) || (load_addr == LAST_ADDR))) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            o_pipe_reset = 1'b1;
            if (flush_cnt == FLUSH_LAST) state_next = ST_IDLE;
         end
         ST_RUN: begin
            o_pipe_valid = 1'b1;
            o_cmd_ready  = 1'b1;
            if (i_halt_retired) state_next = ST_DONE;
            else if (i_cmd_valid && (i_cmd == CMD_STOP)) state_next = ST_IDLE;
         end
         ST_STEP: begin
            o_pipe_valid = 1'b1;
            state_next   = i_halt_retired ? ST_DONE : ST_IDLE;
         end
         ST_DONE: begin
            o_cmd_ready = 1'b1;
            o_done      = 1'b1;
            if (i_cmd_valid && (i_cmd == CMD_LOAD)) begin
               state_next = ST_LOAD;
               addr_clear = 1'b1;
            end else if (i_cmd_valid && (i_cmd == CMD_FLUSH)) begin
               state_next = ST_FLUSH;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         load_addr <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_next;
         if (addr_clear) load_addr <= '0;
         else if (o_imem_wr_en) load_addr <= load_addr + 1'b1;
         flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;
      end
   end

   sat_counter #(
      .NB_CNT (NB_CNT)
   ) u_cycle_counter (
      .clock  (i_clock),
      .reset  (i_reset),
      .clear  (state == ST_FLUSH),
      .enable (o_pipe_valid),
      .count  (o_cycle_count)
   );

   assign o_state = state;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb/tb_pipeline_run_controller.sv - vector table plus directed sequences for pipeline_run_controller
module tb_pipeline_run_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic [2:0]  cmd;
   logic        cmd_ready;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [31:0] wr_data;
   logic        halt;
   logic        pipe_valid;
   logic        pipe_reset;
   logic [31:0] cycle_count;
   logic        done;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   pipeline_run_controller dut (
      .i_clock        (clock),
      .i_reset        (reset),
      .i_cmd_valid    (cmd_valid),
      .i_cmd          (cmd),
      .o_cmd_ready    (cmd_ready),
      .i_load_valid   (load_valid),
      .i_load_data    (load_data),
      .o_load_ready   (load_ready),
      .o_imem_wr_en   (wr_en),
      .o_imem_wr_addr (wr_addr),
      .o_imem_wr_data (wr_data),
      .i_halt_retired (halt),
      .o_pipe_valid   (pipe_valid),
      .o_pipe_reset   (pipe_reset),
      .o_cycle_count  (cycle_count),
      .o_done         (done),
      .o_state        (state)
   );

   typedef struct {
      logic        cv;
      logic [2:0]  cmd;
      logic        lv;
      logic [31:0] ld;
      logic        halt;
      logic [2:0]  st;
      logic        crdy;
      logic        lrdy;
      logic        wen;
      logic [10:0] addr;
      logic        pv;
      logic        pr;
      logic        done;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs [26];

   function automatic vec_t mk(input int cv, input int c, input int lv, input logic [31:0] ld,
                               input int h, input int st, input int crdy, input int lrdy,
                               input int wen, input int addr, input int pv, input int pr,
                               input int dn, input int cnt);
      vec_t v;
      v.cv = cv[0];     v.cmd = c[2:0];    v.lv = lv[0];      v.ld = ld;
      v.halt = h[0];    v.st = st[2:0];    v.crdy = crdy[0];  v.lrdy = lrdy[0];
      v.wen = wen[0];   v.addr = addr[10:0]; v.pv = pv[0];    v.pr = pr[0];
      v.done = dn[0];   v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cv, input logic [2:0] c, input logic lv,
                        input logic [31:0] d, input logic h);
      cmd_valid = cv; cmd = c; load_valid = lv; load_data = d; halt = h;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         drive(0, 0, 0, 0, 0);
         tick();
      end
   endtask

   int pv_seen;

   initial begin
      // cv cmd lv data halt | state crdy lrdy wen addr pv pr done cnt
      vecs[0]  = mk(0, 0, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 1, 32'h20010005, 0,  1, 0, 1, 1, 0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 0, 0, 0,            0,  1, 0, 1, 0, 1, 0, 0, 0, 0);
      vecs[4]  = mk(0, 0, 1, 32'h20020003, 0,  1, 0, 1, 1, 1, 0, 0, 0, 0);
      vecs[5]  = mk(0, 0, 1, 32'hFFFFFFFF, 0,  1, 0, 1, 1, 2, 0, 0, 0, 0);
      vecs[6]  = mk(1, 2, 0, 0,            0,  2, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[7]  = mk(0, 0, 0, 0,            0,  2, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[8]  = mk(1, 3, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0,            0,  4, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[10] = mk(1, 3, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 1);
      vecs[11] = mk(0, 0, 0, 0,            0,  4, 0, 0, 0, 0, 1, 0, 0, 1);
      vecs[12] = mk(1, 3, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 2);
      vecs[13] = mk(0, 0, 0, 0,            0,  4, 0, 0, 0, 0, 1, 0, 0, 2);
      vecs[14] = mk(1, 4, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 3);
      vecs[15] = mk(1, 3, 1, 32'h12345678, 0,  0, 1, 0, 0, 0, 0, 0, 0, 3);
      vecs[16] = mk(0, 0, 0, 0,            1,  4, 0, 0, 0, 0, 1, 0, 0, 3);
      vecs[17] = mk(1, 2, 0, 0,            0,  5, 1, 0, 0, 0, 0, 0, 1, 4);
      vecs[18] = mk(1, 3, 0, 0,            1,  5, 1, 0, 0, 0, 0, 0, 1, 4);
      vecs[19] = mk(1, 6, 0, 0,            0,  5, 1, 0, 0, 0, 0, 0, 1, 4);
      vecs[20] = mk(1, 5, 0, 0,            0,  5, 1, 0, 0, 0, 0, 0, 1, 4);
      vecs[21] = mk(0, 0, 0, 0,            0,  2, 0, 0, 0, 0, 0, 1, 0, 4);
      vecs[22] = mk(0, 0, 0, 0,            0,  2, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[23] = mk(1, 2, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[24] = mk(1, 4, 0, 0,            0,  3, 1, 0, 0, 0, 1, 0, 0, 0);
      vecs[25] = mk(0, 0, 0, 0,            0,  0, 1, 0, 0, 0, 0, 0, 0, 1);

      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      for (int i = 0; i < 26; i++) begin
         drive(vecs[i].cv, vecs[i].cmd, vecs[i].lv, vecs[i].ld, vecs[i].halt);
         @(negedge clock);
         check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].crdy));
         check($sformatf("v%0d_load_ready", i), 32'(load_ready), 32'(vecs[i].lrdy));
         check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wen));
         check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
         if (vecs[i].wen) check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].ld);
         check($sformatf("v%0d_pipe_valid", i), 32'(pipe_valid), 32'(vecs[i].pv));
         check($sformatf("v%0d_pipe_reset", i), 32'(pipe_reset), 32'(vecs[i].pr));
         check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
         check($sformatf("v%0d_count", i), cycle_count, vecs[i].cnt);
         tick();
      end

      // Free run with halt retiring on the tenth valid cycle.
      drive(1, 5, 0, 0, 0); tick();
      idle_cycles(2);
      drive(1, 2, 0, 0, 0); tick();
      pv_seen = 0;
      for (int i = 1; i <= 10; i++) begin
         drive(0, 0, 0, 0, (i == 10));
         @(negedge clock);
         if (pipe_valid) pv_seen++;
         tick();
      end
      check("run_valid_cycles", 32'(pv_seen), 32'd10);
      drive(1, 2, 0, 0, 0);
      @(negedge clock);
      check("run_done_state", 32'(state), 32'd5);
      check("run_done_flag", 32'(done), 32'd1);
      check("run_count", cycle_count, 32'd10);
      check("run_frozen", 32'(pipe_valid), 32'd0);
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clock);
      check("rerun_ignored_state", 32'(state), 32'd5);
      check("rerun_ignored_count", cycle_count, 32'd10);

      // STOP and halt together: halt wins.
      tick();
      drive(1, 5, 0, 0, 0); tick();
      idle_cycles(2);
      drive(1, 2, 0, 0, 0); tick();
      drive(1, 4, 0, 0, 1);
      @(negedge clock);
      check("stop_halt_in_run", 32'(state), 32'd3);
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clock);
      check("stop_halt_state", 32'(state), 32'd5);
      check("stop_halt_count", cycle_count, 32'd1);

      // Full-depth load ends in FLUSH without wrapping.
      tick();
      drive(1, 1, 0, 0, 0); tick();
      for (int i = 0; i < 2048; i++) begin
         drive(0, 0, 1, 32'(i + 1), 0);
         @(negedge clock);
         check($sformatf("full_load_w%0d", i), {20'd0, wr_en, wr_addr}, {20'd0, 1'b1, 11'(i)});
         tick();
      end
      drive(0, 0, 1, 32'h7, 0);
      @(negedge clock);
      check("full_load_state", 32'(state), 32'd2);
      check("full_load_no_wrap", 32'(wr_en), 32'd0);
      tick();
      idle_cycles(1);
      drive(0, 0, 0, 0, 0);
      @(negedge clock);
      check("full_load_idle", 32'(state), 32'd0);

      // Reset in the middle of a load.
      tick();
      drive(1, 1, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 32'h100 + 32'(i), 0);
         tick();
      end
      reset = 1'b1;
      drive(0, 0, 1, 32'h200, 0);
      tick();
      reset = 1'b0;
      drive(0, 0, 1, 32'h300, 0);
      @(negedge clock);
      check("reset_mid_load_state", 32'(state), 32'd0);
      check("reset_mid_load_wr_en", 32'(wr_en), 32'd0);
      check("reset_mid_load_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      drive(1, 1, 0, 0, 0); tick();
      drive(0, 0, 1, 32'h400, 0);
      @(negedge clock);
      check("reload_wr_en", 32'(wr_en), 32'd1);
      check("reload_addr", 32'(wr_addr), 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
- Sequences the MIPS pipeline from a debug-side command interface.
- Arbitrates the instruction-memory write port: a program loader owns it during LOAD, and the fetch stage reads it at all other times.
- Drives the pipeline-wide valid (fetch i_valid) and a pipeline flush reset.
- Supports free-run until a HALT retires, or single-stepping one clock at a time, and keeps a run-cycle counter.

Parameters:
- NB_INSTR, 32, instruction/load word width.
- N_ADDR, 2048, instruction memory depth in words.
- LOG2_N_INSMEM_ADDR, clogb2(N_ADDR), word-address width.
- NB_CNT, 32, cycle counter width.
- FLUSH_CYCLES, 2, cycles o_pipe_reset is held (>=1).
- HALT_INSTR, 32'hFFFF_FFFF, halt opcode; terminates load.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- i_cmd  in  3  0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 STOP, 5 FLUSH; 6-7 reserved.
- o_cmd_ready  out  1  command accepted this cycle if i_cmd_valid.
- i_load_valid  in  1  load word present.
- i_load_data  in  NB_INSTR  load word.
- o_load_ready  out  1  loader may transfer.
- o_imem_wr_en  out  1  instruction memory write enable.
- o_imem_wr_addr  out  LOG2_N_INSMEM_ADDR  word address.
- o_imem_wr_data  out  NB_INSTR  write data.
- i_halt_retired  in  1  HALT instruction reached writeback.
- o_pipe_valid  out  1  pipeline advance enable (fetch i_valid).
- o_pipe_reset  out  1  synchronous pipeline flush.
- o_cycle_count  out  NB_CNT  cycles with o_pipe_valid=1 since last flush.
- o_done  out  1  program halted.
- o_state  out  3  current FSM state (debug).

Behaviour:
- i_reset: state IDLE, load address 0, cycle count 0. All outputs 0 except o_cmd_ready=1. i_reset mid-LOAD/RUN aborts immediately; memory contents are left untouched.
- Command handshake: a command is accepted when i_cmd_valid and o_cmd_ready are both high. The state changes at the next edge. Undefined commands, and commands illegal in the current state, are accepted and ignored (no-op).
- o_cmd_ready, o_load_ready, o_pipe_valid, o_imem_wr_* and o_done are decoded combinationally from state/inputs. o_cycle_count and state are registered.
- IDLE: o_cmd_ready=1. LOAD goes to LOAD with addr=0. RUN goes to RUN. STEP goes to STEP. FLUSH goes to FLUSH. STOP is a no-op.
- LOAD:
  - o_cmd_ready=0, o_load_ready=1.
  - o_imem_wr_en = i_load_valid, with wr_data = i_load_data and wr_addr = load address.
  - Address increments per written word.
  - Writing HALT_INSTR, or writing address N_ADDR-1, transitions to FLUSH after that write (no wrap).
  - o_pipe_valid=0 throughout, so fetch is frozen.
- FLUSH:
  - o_pipe_reset=1 for exactly FLUSH_CYCLES cycles.
  - Cycle count and o_done are cleared.
  - Then goes to IDLE.
  - o_cmd_ready=0.
- RUN:
  - o_pipe_valid=1 every cycle; count increments each cycle, saturating at all-ones.
  - o_cmd_ready=1, but only STOP acts (goes to IDLE).
  - i_halt_retired goes to DONE; that cycle is counted.
  - If STOP and halt occur in the same cycle, DONE wins.
- STEP:
  - Exactly one cycle with o_pipe_valid=1; count increments.
  - Next state is DONE if i_halt_retired in that cycle, else IDLE.
  - o_cmd_ready=0.
- DONE:
  - o_done=1, o_cmd_ready=1.
  - LOAD goes to LOAD; FLUSH goes to FLUSH.
  - RUN, STEP and STOP are ignored; the pipeline stays frozen.
- i_halt_retired outside RUN/STEP is ignored.
- i_load_valid outside LOAD is ignored: no write, o_load_ready=0.

Decomposition:
- Package holds:
  - command codes (CMD_NOP..CMD_FLUSH);
  - state encoding: IDLE=0, LOAD=1, FLUSH=2, RUN=3, STEP=4, DONE=5;
  - HALT_INSTR default;
  - clogb2 function.
- One sub-module: sat_counter (NB_CNT; clear, enable; saturating), instantiated for the cycle count. The FLUSH-length counter stays inline.

Test Plan:
- Reset then idle: o_cmd_ready=1; o_pipe_valid, o_pipe_reset, o_imem_wr_en and o_cycle_count all 0.
- LOAD, then words 0x20010005, 0x20020003 with a 1-cycle i_load_valid gap, then 0xFFFFFFFF -> writes at addr 0, 1, 2. o_pipe_reset is high for 2 cycles, then IDLE with count=0.
- RUN; assert i_halt_retired at the 10th valid cycle -> exactly 10 o_pipe_valid cycles, o_cycle_count=10, o_done=1. A subsequent RUN is ignored.
- STEP three times -> three single-cycle o_pipe_valid pulses, count=3, state back in IDLE each time. STEP with halt in the same cycle -> DONE.
- RUN, then STOP and i_halt_retired in the same cycle -> DONE. Separately, RUN then STOP alone -> IDLE with count preserved.
- Loader streams 2048 non-halt words -> last write at addr 2047, then FLUSH with no wrap. Separately, i_reset asserted mid-LOAD -> IDLE, load address 0 on the next LOAD.
